hazard_sched: RTL
=================

// Module: hazard_sched
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage core (IF/ID/EX/LS/WB). Watches the
//  ID-stage source registers against in-flight destinations in EX/LS/WB, drives
//  operand-forward selects, holds ID on load-use until the LS load completes, and
//  flushes IF/ID on branch/jump/trap redirect. Keeps saturating stall/flush counters.
// PARAMETERS
//  DRAIN_CYCLES  1   cycles flush_if/flush_id stay high per redirect (>=1)
//  CNT_W         32  width of perf counters
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  id_valid    in   1      ID holds a valid instruction
//  id_ra       in   5      ID rs1;  id_ra_en in 1: rs1 actually read
//  id_rb       in   5      ID rs2;  id_rb_en in 1: rs2 actually read
//  ex_valid    in   1      EX valid; ex_rd in 5; ex_wreg in 1; ex_load in 1 (memtoreg)
//  ls_valid    in   1      LS valid; ls_rd in 5; ls_wreg in 1; ls_load in 1
//  ls_done     in   1      LS load data returned this cycle
//  wb_valid    in   1      WB valid; wb_rd in 5; wb_wreg in 1
//  redirect    in   1      EX branch taken / jal / jalr / ecall / mret this cycle
//  stall_id    out  1      hold IF and ID, inject bubble into EX
//  flush_if    out  1      kill IF instruction
//  flush_id    out  1      kill ID instruction
//  fwd_a       out  2      rs1 source: 0 regfile, 1 EX, 2 LS, 3 WB
//  fwd_b       out  2      rs2 source: same encoding
//  stall_cnt   out  CNT_W  cycles with stall_id=1 (saturating)
//  flush_cnt   out  CNT_W  redirect events accepted (saturating)
// BEHAVIOUR
//  Match(X,r,en): X_valid & X_wreg & X_rd!=0 & X_rd==r & en.
//  Forwarding (combinational, youngest wins): EX match and !ex_load ->1; else LS
//   match (if ls_load, only when ls_done) ->2; else WB match ->3; else 0.
//   fwd_* = 0 when id_valid=0.
//  lu_hz = id_valid & ex_load & (Match(ex,id_ra,id_ra_en) | Match(ex,id_rb,id_rb_en)).
//  FSM states: RUN, LDWAIT, DRAIN. Reset -> RUN, drain counter 0, counters 0.
//  RUN: redirect -> flush_if=flush_id=1 this cycle, flush_cnt++; next DRAIN if
//   DRAIN_CYCLES>1 (cnt=DRAIN_CYCLES-2) else RUN. Else lu_hz -> stall_id=1, next
//   LDWAIT. Else outputs 0.
//  LDWAIT: stall_id=1 until the dependent load (now in LS) has ls_done=1; that cycle
//   stall_id=0, fwd=2, next RUN. redirect in LDWAIT overrides: stall_id=0, flush
//   as in RUN, wait aborted.
//  DRAIN: flush_if=flush_id=1, stall_id=0; cnt==0 -> RUN else cnt--. New redirect
//   in DRAIN reloads cnt=DRAIN_CYCLES-1 and increments flush_cnt.
//  Priority: rst > redirect > load-use. stall_id and flush_* never both 1.
//  stall/flush/fwd are combinational from state+inputs (0-cycle latency); counters
//   update on the next edge and hold at all-ones.
//  x0 never forwarded nor stalled on. rst mid-LDWAIT/DRAIN -> RUN, outputs 0 next cycle.
// TESTING
//  ex: add x5 (ex_wreg=1,ex_rd=5), ID reads x5 on rs1 -> fwd_a=1, stall_id=0.
//  ex lw x6, ID add x7,x6,x6 -> stall_id=1 cycle 0; ls_done at cycle 2 -> stall 2
//   cycles, fwd_a=fwd_b=2 on cycle 2, stall_cnt=2.
//  DRAIN_CYCLES=2, redirect pulse -> flush_if/id high 2 cycles, flush_cnt=1; redirect
//   during LDWAIT -> stall drops same cycle, flush asserted.
//  ex_rd=0 with ex_wreg=1, ID rs1=x0 -> fwd_a=0, no stall; id_ra_en=0 -> no match.
//  EX,LS,WB all write x9, ID reads x9 -> fwd=1; kill EX -> 2; kill LS -> 3.
//  Force stall_cnt to all-ones, hold stall -> stays all-ones; rst in LDWAIT -> all 0.

Source files
------------

// File: rtl/hazard_sched.sv
// ============================================================================
//  Module   : hazard_sched
//  Purpose  : Hazard scheduler for the 5-stage core: operand forwarding,
//             load-use stall, redirect flush and saturating perf counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_sched #(
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_ra,
    input  logic             id_ra_en,
    input  logic [4:0]       id_rb,
    input  logic             id_rb_en,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wreg,
    input  logic             ex_load,
    input  logic             ls_valid,
    input  logic [4:0]       ls_rd,
    input  logic             ls_wreg,
    input  logic             ls_load,
    input  logic             ls_done,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wreg,
    input  logic             redirect,
    output logic             stall_id,
    output logic             flush_if,
    output logic             flush_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LDWAIT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int c_drain_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_drain_w-1:0] c_first  =
        c_drain_w'((DRAIN_CYCLES > 1) ? (DRAIN_CYCLES - 2) : 0);
    localparam logic [c_drain_w-1:0] c_reload = c_drain_w'(DRAIN_CYCLES - 1);
    localparam state_t c_redir_next = (DRAIN_CYCLES > 1) ? ST_DRAIN : ST_RUN;

    state_t                 r_state;
    logic [c_drain_w-1:0]   r_drain_cnt;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic [CNT_W-1:0]       r_flush_cnt;

    logic w_ex_a, w_ex_b, w_ls_a, w_ls_b, w_wb_a, w_wb_b;
    logic w_ls_ok;
    logic w_lu_hz;
    logic w_stall;
    logic w_flush;

    function automatic logic f_match(input logic v, input logic wreg,
                                     input logic [4:0] rd, input logic [4:0] r,
                                     input logic en);
        return v & wreg & (rd != 5'd0) & (rd == r) & en;
    endfunction

    // Youngest producer wins; a pending load in EX can never be a source.
    function automatic logic [1:0] f_sel(input logic vld, input logic ex_m,
                                         input logic ls_m, input logic wb_m);
        logic [1:0] sel;
        sel = 2'd0;
        if (vld) begin
            if (ex_m)
                sel = 2'd1;
            else if (ls_m)
                sel = 2'd2;
            else if (wb_m)
                sel = 2'd3;
        end
        return sel;
    endfunction

    assign w_ls_ok = !ls_load || ls_done;

    assign w_ex_a = f_match(ex_valid, ex_wreg, ex_rd, id_ra, id_ra_en);
    assign w_ex_b = f_match(ex_valid, ex_wreg, ex_rd, id_rb, id_rb_en);
    assign w_ls_a = f_match(ls_valid, ls_wreg, ls_rd, id_ra, id_ra_en) & w_ls_ok;
    assign w_ls_b = f_match(ls_valid, ls_wreg, ls_rd, id_rb, id_rb_en) & w_ls_ok;
    assign w_wb_a = f_match(wb_valid, wb_wreg, wb_rd, id_ra, id_ra_en);
    assign w_wb_b = f_match(wb_valid, wb_wreg, wb_rd, id_rb, id_rb_en);

    assign fwd_a = f_sel(id_valid, w_ex_a & !ex_load, w_ls_a, w_wb_a);
    assign fwd_b = f_sel(id_valid, w_ex_b & !ex_load, w_ls_b, w_wb_b);

    assign w_lu_hz = id_valid & ex_load & (w_ex_a | w_ex_b);

    // Redirect always outranks a stall, so flush and stall are exclusive.
    always_comb begin
        w_stall = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect)
                    w_flush = 1'b1;
                else if (w_lu_hz)
                    w_stall = 1'b1;
            end
            ST_LDWAIT: begin
                if (redirect)
                    w_flush = 1'b1;
                else if (!ls_done)
                    w_stall = 1'b1;
            end
            ST_DRAIN: begin
                w_flush = 1'b1;
            end
            default: begin
                w_stall = 1'b0;
                w_flush = 1'b0;
            end
        endcase
    end

    assign stall_id  = w_stall;
    assign flush_if  = w_flush;
    assign flush_id  = w_flush;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect) begin
                        r_state     <= c_redir_next;
                        r_drain_cnt <= c_first;
                    end else if (w_lu_hz) begin
                        r_state <= ST_LDWAIT;
                    end
                end
                ST_LDWAIT: begin
                    if (redirect) begin
                        r_state     <= c_redir_next;
                        r_drain_cnt <= c_first;
                    end else if (ls_done) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (redirect)
                        r_drain_cnt <= c_reload;
                    else if (r_drain_cnt == '0)
                        r_state <= ST_RUN;
                    else
                        r_drain_cnt <= r_drain_cnt - c_drain_w'(1);
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire
